maxpool_relu_stream: RTL and testbench

MAXPOOL_RELU_STREAM -- requirements
Module: maxpool_relu_stream

---
 rtl/cnn_pkg.sv | 23 ++
 rtl/maxpool_relu_stream_if.sv | 36 +++
 rtl/pool_row_buffer.sv | 35 +++
 rtl/maxpool_relu_stream.sv | 177 +++++++++++++++++
 tb/tb_maxpool_relu_stream.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared element type, default geometry and signed max helper
// Purpose: common definitions for the CNN streaming blocks.
//   elem_t       : default-width signed element
//   wide_elem_t  : widest supported element, used by smax so that any
//                  DATA_WIDTH up to MAX_ELEM_WIDTH can share one function
//   smax         : two's-complement signed maximum (ties return a, which
//                  equals b, so the choice is invisible)
package cnn_pkg;

   localparam int DEF_DATA_WIDTH = 16;
   localparam int DEF_POOL       = 2;
   localparam int DEF_IMG_W      = 28;
   localparam int DEF_IMG_H      = 28;
   localparam int MAX_ELEM_WIDTH = 64;

   typedef logic signed [DEF_DATA_WIDTH-1:0] elem_t;
   typedef logic signed [MAX_ELEM_WIDTH-1:0] wide_elem_t;

   function automatic wide_elem_t smax(input wide_elem_t a, input wide_elem_t b);
      return (a >= b) ? a : b;
   endfunction

endpackage

// File: rtl/maxpool_relu_stream_if.sv
// rtl/maxpool_relu_stream_if.sv - pixel-in / pooled-pixel-out handshake bundle
// Purpose: groups the input and output stream signals of maxpool_relu_stream.
// Signals:
//   in_valid/in_ready/in_data        : raster-order input pixels, CH lanes
//   out_valid/out_ready/out_data     : pooled output pixels, same packing
//   out_addr                         : linear index of the current output
//   frame_done                       : pulse after the last output of a frame
// Modports:
//   slave  : the pooling block (consumes pixels, produces pooled pixels)
//   master : the environment driving pixels and accepting results
interface maxpool_relu_stream_if #(
   parameter int DATA_WIDTH = cnn_pkg::DEF_DATA_WIDTH,
   parameter int CH         = 4,
   parameter int ADDR_WIDTH = 10
);

   logic                       in_valid;
   logic                       in_ready;
   logic [CH*DATA_WIDTH-1:0]   in_data;
   logic                       out_valid;
   logic                       out_ready;
   logic [CH*DATA_WIDTH-1:0]   out_data;
   logic [ADDR_WIDTH-1:0]      out_addr;
   logic                       frame_done;

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_addr, frame_done
   );

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_addr, frame_done
   );

endinterface

// File: rtl/pool_row_buffer.sv
// rtl/pool_row_buffer.sv - one row of partial window maxima
// Purpose: holds the vertically-partial window value for every window column
//          of the current pooled row. Contents are never reset: the first
//          row of each window overwrites its entry before it is read.
// Ports:
//   clk     : clock
//   rd_addr : window column to read (combinational read)
//   rd_data : stored partial maximum for rd_addr
//   wr_en   : write strobe, sampled on the rising clock edge
//   wr_addr : window column to write
//   wr_data : new partial maximum
module pool_row_buffer #(
   parameter int DEPTH = 14,
   parameter int WIDTH = 64,
   localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   assign rd_data = mem[rd_addr];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

endmodule

// File: rtl/maxpool_relu_stream.sv
// rtl/maxpool_relu_stream.sv - streaming POOLxPOOL max pooling with optional ReLU
// Purpose: consumes raster-order pixels (CH lanes per beat) and emits one
//          pooled pixel per non-overlapping POOLxPOOL window, with its linear
//          output index. Optional feature macro: MAXPOOL_RELU_EN clamps
//          negative pooled values to zero.
// Ports:
//   clk        : clock
//   reset      : synchronous, active-high
//   clear      : abort the current frame (counters, accumulator, output state)
//   bus        : maxpool_relu_stream_if.slave stream bundle
module maxpool_relu_stream
   import cnn_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int CH         = 4,
   parameter int POOL       = DEF_POOL,
   parameter int IMG_W      = DEF_IMG_W,
   parameter int IMG_H      = DEF_IMG_H,
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clear,
   maxpool_relu_stream_if.slave  bus
);

   localparam int WW   = IMG_W / POOL;
   localparam int WH   = IMG_H / POOL;
   localparam int NOUT = WW * WH;
   localparam int PW   = (POOL > 1) ? $clog2(POOL) : 1;
   localparam int WCW  = (WW > 1) ? $clog2(WW) : 1;
   localparam int VW   = CH * DATA_WIDTH;

   generate
      if (POOL < 2 || POOL > 4) begin : g_bad_pool
         $error("maxpool_relu_stream: POOL must be in 2..4");
      end
      if ((IMG_W % POOL) != 0 || (IMG_H % POOL) != 0) begin : g_bad_geom
         $error("maxpool_relu_stream: IMG_W and IMG_H must be multiples of POOL");
      end
      if (longint'(NOUT) > (longint'(1) << ADDR_WIDTH)) begin : g_bad_addr
         $error("maxpool_relu_stream: ADDR_WIDTH too small for the output count");
      end
      if (DATA_WIDTH < 1 || DATA_WIDTH > MAX_ELEM_WIDTH) begin : g_bad_width
         $error("maxpool_relu_stream: DATA_WIDTH out of range");
      end
   endgenerate

   typedef logic signed [DATA_WIDTH-1:0] ch_t;

   function automatic ch_t ch_max(input ch_t a, input ch_t b);
      return DATA_WIDTH'(smax(wide_elem_t'(a), wide_elem_t'(b)));
   endfunction

   // Position inside the frame: cp/rp are the offsets inside the current
   // window, wcol is the window column. The window row is not needed because
   // the end of the frame is tracked by out_addr.
   logic [PW-1:0]  cp;
   logic [PW-1:0]  rp;
   logic [WCW-1:0] wcol;
   logic [VW-1:0]  acc_q;

   logic [VW-1:0]  acc_new;
   logic [VW-1:0]  win_val;
   logic [VW-1:0]  out_next;
   logic [VW-1:0]  buf_rd;

   logic accept;
   logic out_fire;
   logic cp_last;
   logic rp_first;
   logic rp_last;
   logic win_done;
   logic buf_we;
   logic last_addr;

   // clear and reset block acceptance, which is also what discards a beat
   // presented in the clear cycle.
   assign bus.in_ready = !reset && !clear && (!bus.out_valid || bus.out_ready);

   assign accept    = bus.in_valid && bus.in_ready;
   assign out_fire  = bus.out_valid && bus.out_ready;
   assign cp_last   = (cp == PW'(POOL - 1));
   assign rp_first  = (rp == '0);
   assign rp_last   = (rp == PW'(POOL - 1));
   assign win_done  = accept && cp_last && rp_last;
   assign buf_we    = accept && cp_last && !rp_last;
   assign last_addr = (bus.out_addr == ADDR_WIDTH'(NOUT - 1));

   for (genvar c = 0; c < CH; c++) begin : g_ch
      ch_t in_c;
      ch_t acc_c;
      ch_t buf_c;
      ch_t an_c;
      ch_t w_c;

      assign in_c  = bus.in_data[c*DATA_WIDTH +: DATA_WIDTH];
      assign acc_c = acc_q[c*DATA_WIDTH +: DATA_WIDTH];
      assign buf_c = buf_rd[c*DATA_WIDTH +: DATA_WIDTH];

      // Horizontal max restarts at the first column of each window; the
      // vertical max restarts at the first row, so stale buffer entries
      // from an aborted frame are never used.
      assign an_c = (cp == '0) ? in_c : ch_max(acc_c, in_c);
      assign w_c  = rp_first ? an_c : ch_max(buf_c, an_c);

      assign acc_new[c*DATA_WIDTH +: DATA_WIDTH] = an_c;
      assign win_val[c*DATA_WIDTH +: DATA_WIDTH] = w_c;
`ifdef MAXPOOL_RELU_EN
      assign out_next[c*DATA_WIDTH +: DATA_WIDTH] = w_c[DATA_WIDTH-1] ? '0 : w_c;
`else
      assign out_next[c*DATA_WIDTH +: DATA_WIDTH] = w_c;
`endif
   end

   pool_row_buffer #(
      .DEPTH (WW),
      .WIDTH (VW)
   ) u_rowbuf (
      .clk     (clk),
      .rd_addr (wcol),
      .rd_data (buf_rd),
      .wr_en   (buf_we),
      .wr_addr (wcol),
      .wr_data (win_val)
   );

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         cp    <= '0;
         rp    <= '0;
         wcol  <= '0;
         acc_q <= '0;
      end else if (accept) begin
         acc_q <= acc_new;
         if (cp_last) begin
            cp <= '0;
            if (wcol == WCW'(WW - 1)) begin
               wcol <= '0;
               rp   <= rp_last ? '0 : rp + 1'b1;
            end else begin
               wcol <= wcol + 1'b1;
            end
         end else begin
            cp <= cp + 1'b1;
         end
      end
   end

   // A completing window always reloads the output register, even in the
   // cycle the previous result is taken, so back-to-back windows see no
   // bubble. in_ready guarantees an unaccepted result is never overwritten.
   always_ff @(posedge clk) begin
      if (reset) begin
         bus.out_valid  <= 1'b0;
         bus.out_data   <= '0;
         bus.out_addr   <= '0;
         bus.frame_done <= 1'b0;
      end else if (clear) begin
         bus.out_valid  <= 1'b0;
         bus.out_addr   <= '0;
         bus.frame_done <= 1'b0;
      end else begin
         bus.frame_done <= out_fire && last_addr;
         if (out_fire) begin
            bus.out_addr <= last_addr ? '0 : bus.out_addr + 1'b1;
         end
         if (win_done) begin
            bus.out_valid <= 1'b1;
            bus.out_data  <= out_next;
         end else if (out_fire) begin
            bus.out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_maxpool_relu_stream.sv
// tb/tb_maxpool_relu_stream.sv - directed vector bench for maxpool_relu_stream
// Purpose: 4x4 image, POOL=2, four lanes; frame vectors with hand-computed
//          pooled results plus stall, clear, reset and back-to-back sequences.
module tb_maxpool_relu_stream;

   localparam int DW  = 16;
   localparam int NCH = 4;
   localparam int AW  = 10;

   typedef struct packed {
      logic [NCH-1:0][15:0][DW-1:0] pix;
      logic [NCH-1:0][3:0][DW-1:0]  expd;
   } vec_t;

   vec_t vecs [3];

   logic clk = 1'b0;
   logic reset;
   logic clear;
   int   n_vec    = 0;
   int   n_bad    = 0;
   int   fd_count = 0;

   int ch3_pix [16] = '{-3, 7, -32768, 32767, -8, 7, 0, -1,
                        -100, -100, -2, -7, -100, -100, -1, -9};
   int ch3_exp [4]  = '{7, 32767, -100, -1};
   int seq_exp [4]  = '{6, 8, 14, 16};
   int rev_exp [4]  = '{16, 14, 8, 6};
   int neg_exp [4]  = '{-1, -3, -9, -11};

   maxpool_relu_stream_if #(.DATA_WIDTH(DW), .CH(NCH), .ADDR_WIDTH(AW)) bus ();

   maxpool_relu_stream #(
      .DATA_WIDTH (DW),
      .CH         (NCH),
      .POOL       (2),
      .IMG_W      (4),
      .IMG_H      (4),
      .ADDR_WIDTH (AW)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .clear (clear),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bus.frame_done === 1'b1) fd_count <= fd_count + 1;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, vectors %0d", n_vec);
      $fatal(1);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_vec++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: actual %h required %h", name, act, req);
      end
   endtask

   function automatic logic [63:0] pix_word(input int v, input int i);
      logic [63:0] r;
      r = '0;
      for (int c = 0; c < NCH; c++) r[c*DW +: DW] = vecs[v].pix[c][i];
      return r;
   endfunction

   function automatic logic [63:0] exp_word(input int v, input int wi);
      logic [63:0]   r;
      logic [DW-1:0] e;
      r = '0;
      for (int c = 0; c < NCH; c++) begin
         e = vecs[v].expd[c][wi];
`ifdef MAXPOOL_RELU_EN
         if (e[DW-1]) e = '0;
`endif
         r[c*DW +: DW] = e;
      end
      return r;
   endfunction

   function automatic int win_of(input int i);
      case (i)
         5:       return 0;
         7:       return 1;
         13:      return 2;
         15:      return 3;
         default: return -1;
      endcase
   endfunction

   // Observed one cycle after beat i was accepted.
   task automatic check_beat(input int v, input int i);
      int wi;
      wi = win_of(i);
      if (wi < 0) begin
         check("idle_out_valid", 64'(bus.out_valid), 64'd0);
      end else begin
         check("out_valid", 64'(bus.out_valid), 64'd1);
         check("out_data", bus.out_data, exp_word(v, wi));
         check("out_addr", 64'(bus.out_addr), 64'(wi));
      end
   endtask

   task automatic step(input int v, input int prev, input int nxt);
      @(negedge clk);
      if (prev >= 0) check_beat(v, prev);
      if (nxt >= 0) begin
         check("in_ready", 64'(bus.in_ready), 64'd1);
         bus.in_valid = 1'b1;
         bus.in_data  = pix_word(v, nxt);
      end else begin
         bus.in_valid = 1'b0;
      end
   endtask

   task automatic frame_tail(input int fd0, input int nframes);
      @(negedge clk);
      check("frame_done_pulse", 64'(bus.frame_done), 64'd1);
      repeat (2) @(negedge clk);
      check("frame_done_count", 64'(fd_count - fd0), 64'(nframes));
   endtask

   task automatic run_frames(input int v, input int nframes);
      int n;
      int fd0;
      n   = 16 * nframes;
      fd0 = fd_count;
      for (int k = 0; k <= n; k++) begin
         step(v, (k == 0) ? -1 : (k - 1) % 16, (k < n) ? k % 16 : -1);
      end
      frame_tail(fd0, nframes);
   endtask

   initial begin
      for (int c = 0; c < NCH; c++) begin
         for (int i = 0; i < 16; i++) begin
            vecs[0].pix[c][i] = DW'(i + 1);
            vecs[1].pix[c][i] = DW'(-5);
         end
         for (int w = 0; w < 4; w++) begin
            vecs[0].expd[c][w] = DW'(seq_exp[w]);
            vecs[1].expd[c][w] = DW'(-5);
         end
      end
      for (int i = 0; i < 16; i++) begin
         vecs[2].pix[0][i] = DW'(i + 1);
         vecs[2].pix[1][i] = DW'(16 - i);
         vecs[2].pix[2][i] = DW'(-(i + 1));
         vecs[2].pix[3][i] = DW'(ch3_pix[i]);
      end
      for (int w = 0; w < 4; w++) begin
         vecs[2].expd[0][w] = DW'(seq_exp[w]);
         vecs[2].expd[1][w] = DW'(rev_exp[w]);
         vecs[2].expd[2][w] = DW'(neg_exp[w]);
         vecs[2].expd[3][w] = DW'(ch3_exp[w]);
      end

      // Reset state.
      reset = 1'b1;
      clear = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b1;
      repeat (2) @(negedge clk);
      check("reset_out_valid", 64'(bus.out_valid), 64'd0);
      check("reset_out_data", bus.out_data, 64'd0);
      check("reset_out_addr", 64'(bus.out_addr), 64'd0);
      check("reset_frame_done", 64'(bus.frame_done), 64'd0);
      reset = 1'b0;
      @(negedge clk);
      check("reset_in_ready", 64'(bus.in_ready), 64'd1);

      // Frame vector table.
      for (int v = 0; v < 3; v++) run_frames(v, 1);

      // Back-to-back frames, in_valid never drops: addresses wrap 3 -> 0.
      run_frames(0, 2);

      // Output stall at the first result.
      begin
         int fd0;
         fd0 = fd_count;
         bus.out_ready = 1'b0;
         step(0, -1, 0);
         for (int k = 1; k <= 5; k++) step(0, k - 1, k);
         for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            check("stall_in_ready", 64'(bus.in_ready), 64'd0);
            check("stall_out_valid", 64'(bus.out_valid), 64'd1);
            check("stall_out_data", bus.out_data, exp_word(0, 0));
            check("stall_out_addr", 64'(bus.out_addr), 64'd0);
            if (s == 0) bus.in_data = pix_word(0, 6);
         end
         bus.out_ready = 1'b1;
         for (int k = 7; k <= 16; k++) step(0, k - 1, (k < 16) ? k : -1);
         frame_tail(fd0, 1);
      end

      // Clear after the sixth beat, with a beat offered during clear.
      begin
         int fd0;
         fd0 = fd_count;
         step(0, -1, 0);
         for (int k = 1; k <= 5; k++) step(0, k - 1, k);
         @(negedge clk);
         check_beat(0, 5);
         clear        = 1'b1;
         bus.in_valid = 1'b1;
         bus.in_data  = pix_word(1, 0);
         #1;
         check("clear_in_ready", 64'(bus.in_ready), 64'd0);
         @(negedge clk);
         clear        = 1'b0;
         bus.in_valid = 1'b0;
         check("clear_out_valid", 64'(bus.out_valid), 64'd0);
         check("clear_out_addr", 64'(bus.out_addr), 64'd0);
         check("clear_no_frame_done", 64'(fd_count - fd0), 64'd0);
         run_frames(0, 1);
      end

      // Reset in the middle of a frame, result pending.
      step(2, -1, 0);
      for (int k = 1; k <= 6; k++) step(2, k - 1, k);
      @(negedge clk);
      reset        = 1'b1;
      bus.in_valid = 1'b0;
      @(negedge clk);
      check("midreset_out_valid", 64'(bus.out_valid), 64'd0);
      check("midreset_out_addr", 64'(bus.out_addr), 64'd0);
      check("midreset_out_data", bus.out_data, 64'd0);
      reset = 1'b0;
      run_frames(2, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
